// File: rtl/nes_pll_reset_seq.sv
// nes_pll_reset_seq: PLL reset pulse, lock-wait with retries, stable-lock qualification and core reset release
module nes_pll_reset_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          pll_locked,
  input  logic          relock_req,
  output logic          pll_rst,
  output logic          sys_rst,
  output logic          fault,
  output logic          lock_lost,
  output logic [RW-1:0] retry_count
);
  localparam int CM = (PLL_RST_CYCLES > LOCK_TIMEOUT) ?
                      ((PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES) :
                      ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
  localparam int CW = $clog2(CM + 1);
  typedef enum logic [2:0] {S_PRST, S_WAIT, S_STAB, S_RUN, S_FAULT} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sync_q;
  logic          lk;
  logic          pll_rst_d, sys_rst_d, fault_d, lock_lost_d;
  logic [RW-1:0] retry_d;
  assign lk = sync_q[1];
  // state, counter, synchronizer and registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= S_PRST;
      cnt_q       <= '0;
      sync_q      <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      fault       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= {sync_q[0], pll_locked};
      pll_rst     <= pll_rst_d;
      sys_rst     <= sys_rst_d;
      fault       <= fault_d;
      lock_lost   <= lock_lost_d;
      retry_count <= retry_d;
    end
  end
  // next state; a lock seen in the last timeout cycle beats the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PRST: state_d = (cnt_q == CW'(PLL_RST_CYCLES - 1)) ? S_WAIT : S_PRST;
      S_WAIT: state_d = lk ? S_STAB :
                        (cnt_q != CW'(LOCK_TIMEOUT - 1)) ? S_WAIT :
                        (retry_count == RW'(MAX_RETRIES)) ? S_FAULT : S_PRST;
      S_STAB: state_d = !lk ? S_WAIT : (cnt_q == CW'(STABLE_CYCLES - 1)) ? S_RUN : S_STAB;
      S_RUN:  state_d = (!lk || relock_req) ? S_PRST : S_RUN;
      default: state_d = S_FAULT;
    endcase
  end
  // outputs derived from the upcoming state so they are registered without extra latency
  always_comb begin
    pll_rst_d   = (state_d == S_PRST) || (state_d == S_FAULT);
    sys_rst_d   = state_d != S_RUN;
    fault_d     = state_d == S_FAULT;
    lock_lost_d = lock_lost || (state_q == S_RUN && !lk);
    retry_d     = (state_d == S_RUN) ? '0 :
                  (state_q == S_WAIT && state_d == S_PRST) ? retry_count + 1'b1 : retry_count;
    cnt_d       = (state_d != state_q || state_q == S_RUN || state_q == S_FAULT) ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: tb/tb_nes_pll_reset_seq.sv
// tb_nes_pll_reset_seq: directed checkpoint tables per scenario plus hand-written reset sequences
module tb_nes_pll_reset_seq;
  logic refclk = 1'b0;
  logic rst = 1'b1, pll_locked = 1'b0, relock_req = 1'b0;
  logic pll_rst, sys_rst, fault, lock_lost;
  logic [1:0] retry_count;
  int total = 0, bad = 0;
  nes_pll_reset_seq #(.PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(3)) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .fault(fault), .lock_lost(lock_lost),
    .retry_count(retry_count)
  );
  always #5 refclk = ~refclk;
  typedef struct {int sc; int cyc; logic [5:0] exp;} chk_t;
  chk_t tbl[$];
  int lock_on[1:5] = '{10, -1, 10, 10, 10};
  int low_s[1:5]   = '{-1, -1, 15, 40, 48};
  int low_e[1:5]   = '{-1, -1, 16, 44, 49};
  int len[1:5]     = '{32, 150, 32, 62, 56};
  int rq[1:5][3]   = '{'{-1, -1, -1}, '{-1, -1, -1}, '{-1, -1, -1}, '{-1, -1, -1}, '{8, 30, 50}};
  task automatic step();
    @(posedge refclk);
    #1;
  endtask
  task automatic do_rst(input int n);
    rst = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    repeat (n) step();
    rst = 1'b0;
  endtask
  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {pll_rst, sys_rst, fault, lock_lost, retry_count};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s {pll_rst,sys_rst,fault,lock_lost,retry}: got %b required %b", name, got, exp);
    end
  endtask
  task automatic add(input int sc, input int cyc, input logic pr, input logic sr, input logic f,
                     input logic ll, input logic [1:0] rc);
    tbl.push_back('{sc, cyc, {pr, sr, f, ll, rc}});
  endtask
  initial begin
    add(1, 0, 1, 1, 0, 0, 0);  add(1, 3, 1, 1, 0, 0, 0);  add(1, 4, 0, 1, 0, 0, 0);
    add(1, 12, 0, 1, 0, 0, 0); add(1, 20, 0, 1, 0, 0, 0); add(1, 21, 0, 0, 0, 0, 0);
    add(1, 30, 0, 0, 0, 0, 0);
    add(2, 0, 1, 1, 0, 0, 0);  add(2, 3, 1, 1, 0, 0, 0);  add(2, 4, 0, 1, 0, 0, 0);
    add(2, 23, 0, 1, 0, 0, 0); add(2, 24, 1, 1, 0, 0, 1); add(2, 28, 0, 1, 0, 0, 1);
    add(2, 47, 0, 1, 0, 0, 1); add(2, 48, 1, 1, 0, 0, 2); add(2, 52, 0, 1, 0, 0, 2);
    add(2, 72, 1, 1, 0, 0, 3); add(2, 76, 0, 1, 0, 0, 3); add(2, 95, 0, 1, 0, 0, 3);
    add(2, 96, 1, 1, 1, 0, 3); add(2, 146, 1, 1, 1, 0, 3); add(2, 149, 1, 1, 1, 0, 3);
    add(3, 17, 0, 1, 0, 0, 0); add(3, 21, 0, 1, 0, 0, 0); add(3, 26, 0, 1, 0, 0, 0);
    add(3, 27, 0, 0, 0, 0, 0);
    add(4, 42, 0, 0, 0, 0, 0); add(4, 43, 1, 1, 0, 1, 0); add(4, 46, 1, 1, 0, 1, 0);
    add(4, 47, 0, 1, 0, 1, 0); add(4, 55, 0, 1, 0, 1, 0); add(4, 56, 0, 0, 0, 1, 0);
    add(4, 61, 0, 0, 0, 1, 0);
    add(5, 0, 1, 1, 0, 0, 0);  add(5, 9, 0, 1, 0, 0, 0);  add(5, 21, 0, 0, 0, 0, 0);
    add(5, 30, 0, 0, 0, 0, 0); add(5, 31, 1, 1, 0, 0, 0); add(5, 34, 1, 1, 0, 0, 0);
    add(5, 35, 0, 1, 0, 0, 0); add(5, 43, 0, 1, 0, 0, 0); add(5, 44, 0, 0, 0, 0, 0);
    add(5, 50, 0, 0, 0, 0, 0); add(5, 51, 1, 1, 0, 1, 0);
    for (int s = 1; s <= 5; s++) begin
      do_rst(3);
      for (int c = 0; c < len[s]; c++) begin
        pll_locked = lock_on[s] >= 0 && c >= lock_on[s] && !(c >= low_s[s] && c < low_e[s]);
        relock_req = c == rq[s][0] || c == rq[s][1] || c == rq[s][2];
        foreach (tbl[i])
          if (tbl[i].sc == s && tbl[i].cyc == c) check($sformatf("sc%0d_c%0d", s, c), tbl[i].exp);
        step();
      end
    end
    do_rst(3);
    repeat (100) step();
    check("fault_before_rst", 6'b111011);
    do_rst(1);
    check("rst_in_fault", 6'b110000);
    step();
    step();
    do_rst(1);
    check("rst_mid_pulse_c0", 6'b110000);
    repeat (3) step();
    check("rst_mid_pulse_c3", 6'b110000);
    step();
    check("rst_mid_pulse_c4", 6'b010000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
